// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out
// frame driven on device clock falls, then device ack check with timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_pull,
    output logic       ps2_data_pull,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned INH_W   = 14;
    localparam int unsigned TO_W    = 21;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned FLT_W   = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] frame, frame_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [INH_W-1:0]   inh_cnt, inh_nxt;
    logic [TO_W-1:0]    to_cnt, to_nxt;
    logic               clk_pull_nxt, data_pull_nxt;
    logic               done_nxt, err_nxt;

    logic               clk_meta, clk_sync, data_meta, data_sync;
    logic               clk_filt;
    logic [FLT_W-1:0]   flt_cnt;
    logic               flt_hit_c;
    logic               fall_c;

    // Pin synchronizers plus clock-line glitch filter; lines idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_hit_c) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    assign flt_hit_c = (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign fall_c    = clk_filt && !clk_sync && flt_hit_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            frame         <= '0;
            bit_cnt       <= '0;
            inh_cnt       <= '0;
            to_cnt        <= '0;
            ps2_clk_pull  <= 1'b0;
            ps2_data_pull <= 1'b0;
            busy          <= 1'b0;
            tx_ready      <= 1'b1;
            tx_done       <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame         <= frame_nxt;
            bit_cnt       <= bit_nxt;
            inh_cnt       <= inh_nxt;
            to_cnt        <= to_nxt;
            ps2_clk_pull  <= clk_pull_nxt;
            ps2_data_pull <= data_pull_nxt;
            busy          <= (state_nxt != S_IDLE);
            tx_ready      <= (state_nxt == S_IDLE);
            tx_done       <= done_nxt;
            tx_err        <= err_nxt;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt     = state;
        frame_nxt     = frame;
        bit_nxt       = bit_cnt;
        inh_nxt       = inh_cnt;
        to_nxt        = to_cnt;
        clk_pull_nxt  = ps2_clk_pull;
        data_pull_nxt = ps2_data_pull;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    frame_nxt    = {1'b1, ~^tx_data, tx_data};
                    bit_nxt      = '0;
                    inh_nxt      = '0;
                    clk_pull_nxt = 1'b1;
                    state_nxt    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_pull_nxt = 1'b1;
                if (inh_cnt >= INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_pull_nxt = 1'b1;
                    state_nxt     = S_REQ;
                end else if (inh_cnt != '1) begin
                    inh_nxt = inh_cnt + INH_W'(1);
                end
            end
            S_REQ: begin
                clk_pull_nxt = 1'b0;
                to_nxt       = '0;
                state_nxt    = S_SEND;
            end
            S_SEND, S_ACK, S_WAIT_IDLE: begin
                if (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    if (to_cnt != '1) begin
                        to_nxt = to_cnt + TO_W'(1);
                    end
                    if (state == S_SEND) begin
                        if (fall_c) begin
                            data_pull_nxt = ~frame[bit_cnt];
                            bit_nxt       = bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                                state_nxt = S_ACK;
                            end
                        end
                    end else if (state == S_ACK) begin
                        data_pull_nxt = 1'b0;
                        if (fall_c) begin
                            if (!data_sync) begin
                                state_nxt = S_WAIT_IDLE;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = S_IDLE;
                            end
                        end
                    end else begin
                        if (clk_filt && data_sync) begin
                            done_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Both lines are always released on the way back to idle.
        if (state_nxt == S_IDLE) begin
            clk_pull_nxt  = 1'b0;
            data_pull_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus model with a clocking PS/2 device,
// frame contents compared to a byte/parity model, timing and fault paths checked.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 100;
    localparam int unsigned TO   = 5000;
    localparam int unsigned FLT  = 2;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_pull, ps2_data_pull;
    logic       busy, tx_done, tx_err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    int checks   = 0;
    int failures = 0;

    int   n_done = 0, n_err = 0, n_drop_done = 0, n_drop_err = 0, n_both = 0;
    logic busy_q = 1'b0;
    bit   rx_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clk_pull (ps2_clk_pull),
        .ps2_data_pull(ps2_data_pull),
        .busy         (busy),
        .tx_done      (tx_done),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    // Wired-AND of host pulls and device drive on the shared lines.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_pull;
    assign ps2_data_in = dev_data & ~ps2_data_pull;

    // Pulse bookkeeping, including what accompanied each busy drop.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy;
            if (tx_done) n_done <= n_done + 1;
            if (tx_err) n_err <= n_err + 1;
            if (tx_done && tx_err) n_both <= n_both + 1;
            if (busy_q && !busy && tx_done) n_drop_done <= n_drop_done + 1;
            if (busy_q && !busy && tx_err) n_drop_err <= n_drop_err + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected 10-bit frame as seen by the device: data LSB first, odd parity, stop.
    function automatic int model_frame(input logic [7:0] b);
        int f;
        int par;
        par = (($countones(b) % 2) == 0) ? 1 : 0;
        f = int'(b) | (par << 8) | (1 << 9);
        return f;
    endfunction

    // Device: generates nfall clock periods, samples data on each rise, acks before fall 11.
    task automatic dev_run(input int nfall, input bit nack);
        for (int k = 1; k <= nfall; k++) begin
            if (k == 11) begin
                dev_data = nack;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) rx_q.push_back(ps2_data_in);
            repeat (HALF) @(negedge clk);
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    // Accept, inhibit length, request and clock release; optional stray tx_valid mid-inhibit.
    task automatic start_frame(input logic [7:0] b, input bit poke);
        int n;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_clk_pull", int'(ps2_clk_pull), 1);
        chk("accept_busy", int'(busy), 1);
        chk("accept_ready", int'(tx_ready), 0);
        n = 0;
        while (n < int'(INH) + 10 && !ps2_data_pull) begin
            n++;
            tx_valid = poke && (n == int'(INH) / 2);
            if (tx_valid) tx_data = 8'h00;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("inhibit_len", n, int'(INH));
        chk("req_clk_pull", int'(ps2_clk_pull), 1);
        @(negedge clk);
        chk("release_clk_pull", int'(ps2_clk_pull), 0);
        chk("start_data_pull", int'(ps2_data_pull), 1);
    endtask

    task automatic send(input logic [7:0] b, input bit nack, input bit poke);
        int d0, e0, dd0, de0, obs, w;
        d0 = n_done; e0 = n_err; dd0 = n_drop_done; de0 = n_drop_err;
        rx_q.delete();
        start_frame(b, poke);
        repeat (10) @(negedge clk);
        dev_run(11, nack);
        w = 0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        obs = 0;
        for (int i = 0; i < rx_q.size() && i < 10; i++) obs |= int'(rx_q[i]) << i;
        chk("rx_bit_count", rx_q.size(), 10);
        chk("rx_frame", obs, model_frame(b));
        chk("end_busy", int'(busy), 0);
        chk("end_ready", int'(tx_ready), 1);
        chk("end_clk_pull", int'(ps2_clk_pull), 0);
        chk("end_data_pull", int'(ps2_data_pull), 0);
        chk("done_count", n_done - d0, nack ? 0 : 1);
        chk("err_count", n_err - e0, nack ? 1 : 0);
        chk("done_with_busy_drop", n_drop_done - dd0, nack ? 0 : 1);
        chk("err_with_busy_drop", n_drop_err - de0, nack ? 1 : 0);
    endtask

    initial begin
        int m, d0, e0;
        logic [7:0] rb;
        bit rn;

        repeat (3) @(negedge clk);
        chk("reset_clk_pull", int'(ps2_clk_pull), 0);
        chk("reset_data_pull", int'(ps2_data_pull), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(tx_done), 0);
        chk("reset_err", int'(tx_err), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(tx_ready), 1);

        send(8'hED, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0);

        // Device stays silent after the request.
        e0 = n_err; d0 = n_done;
        start_frame(8'h3C, 1'b0);
        m = 0;
        while (m < int'(TO) + 100 && !tx_err) begin
            @(negedge clk);
            m++;
        end
        chk("timeout_cycles", m, int'(TO));
        chk("timeout_clk_pull", int'(ps2_clk_pull), 0);
        chk("timeout_data_pull", int'(ps2_data_pull), 0);
        chk("timeout_busy", int'(busy), 0);
        @(negedge clk);
        chk("timeout_err_count", n_err - e0, 1);
        chk("timeout_done_count", n_done - d0, 0);

        // Async reset in the middle of the data bits.
        e0 = n_err; d0 = n_done;
        rx_q.delete();
        start_frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        dev_run(4, 1'b0);
        chk("mid_send_data_pull", int'(ps2_data_pull), 1);
        chk("mid_send_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_clk_pull", int'(ps2_clk_pull), 0);
        chk("async_data_pull", int'(ps2_data_pull), 0);
        chk("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", int'(tx_ready), 1);
        chk("abort_done_count", n_done - d0, 0);
        chk("abort_err_count", n_err - e0, 0);
        send(8'hF4, 1'b0, 1'b0);

        // Stray tx_valid while busy must not alter or queue anything.
        send(8'h5A, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        chk("no_queued_frame", int'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rn = ($urandom_range(0, 3) == 0);
            send(rb, rn, 1'b0);
        end

        chk("done_err_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
